regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port among NUM_REQ writeback requesters
//   (e.g. ALU result, load return).
//  Round-robin grant with valid/ready handshake. Registers the winner into a one-entry
//   output stage that drives RegWrite/WriteRegister/WriteData.
//  Writes to the zero register are accepted and then dropped.
//  Exposes the output stage as a forwarding tap so readers can bypass the in-flight write.
// PARAMETERS
//  NUM_REQ     2    number of requesters, legal range 2..4
//  DATA_WIDTH  64   write data width
//  ADDR_WIDTH  5    register index width
//  ZERO_REG    31   hardwired-zero register; writes to it never reach the file
// PORTS
//  clk            in   1                      rising-edge clock
//  reset          in   1                      asynchronous, active-high
//  hold           in   1                      1 = issue no grants this cycle
//  req_valid      in   NUM_REQ                requester i has a write pending
//  req_reg        in   NUM_REQ x ADDR_WIDTH   destination register, requester i
//  req_data       in   NUM_REQ x DATA_WIDTH   write data, requester i
//  req_ready      out  NUM_REQ                one-hot grant; transfer when valid & ready
//  RegWrite       out  1                      write enable to register file
//  WriteRegister  out  ADDR_WIDTH             write index to register file
//  WriteData      out  DATA_WIDTH             write data to register file
//  fwd_valid      out  1                      output stage holds a write the file has not yet committed
//  fwd_reg        out  ADDR_WIDTH             = WriteRegister
//  fwd_data       out  DATA_WIDTH             = WriteData
// BEHAVIOUR
//  Reset (async assert, outputs settle immediately):
//   - RegWrite=0, WriteRegister=0, WriteData=0, fwd_valid=0
//   - RR pointer = 0 (requester 0 has highest priority)
//   - req_ready=0 while reset is high
//  Grant (combinational, same cycle):
//   - req_ready[i]=1 for exactly one i, the first valid requester at or after the RR pointer
//     (wrapping modulo NUM_REQ)
//   - All zero when hold=1 or no valid requester
//   - req_ready never depends on the requester's own ready; valid must not wait for ready
//  Pointer: on a grant to i, the pointer becomes (i+1) mod NUM_REQ at the clock edge.
//   Otherwise it is unchanged, including under hold.
//  Output stage (registered, 1-cycle latency):
//   - At the edge after a grant: WriteRegister/WriteData <= req_reg/req_data of the winner
//   - RegWrite <= 1 unless req_reg == ZERO_REG, in which case RegWrite <= 0 (silent drop)
//   - No grant: RegWrite <= 0; WriteRegister/WriteData hold their previous values
//  Commit: the register file samples on the next edge, so total latency from accept to
//   architectural update is 2 edges.
//  Throughput: one write per cycle; the stage never back-pressures.
//  Fairness: a requester holding valid with hold=0 is granted within NUM_REQ cycles.
//  Forwarding: fwd_valid = RegWrite. fwd_* must be used by readers because the file
//   commits one edge later.
//  Same destination from two requesters in one cycle: granted in RR order as separate
//   writes; the later grant wins architecturally. No merging.
//  Requester drops valid without a grant: no effect; the data is never written.
//  Reset mid-operation: the in-flight output-stage write is discarded (RegWrite forced 0);
//   the pointer returns to 0.
//  req_reg is treated as unsigned. No X propagation: all outputs are fully defined after reset.
// STRUCTURE
//  Package regfile_pkg:
//   - DATA_WIDTH, ADDR_WIDTH, ZERO_REG constants
//   - typedef wb_req_t {logic [ADDR_WIDTH-1:0] rd; logic [DATA_WIDTH-1:0] data;}
//   - shared by this block and future forwarding/hazard units
//  Sub-module rr_arbiter #(N): req[N], advance, produces one-hot grant[N]; owns the pointer.
//  Top level: the grant mux, ZERO_REG filter and output-stage flops.
//  Connect RegWrite/WriteRegister/WriteData straight to registerFile.
// TESTING
//  1. Reset, then req_valid=2'b01, reg=3, data=64'hA5
//     -> ready[0]=1 same cycle; next cycle RegWrite=1, WriteRegister=3, WriteData=A5;
//        ReadData of reg 3 = A5 one edge later
//  2. Both valid every cycle, regs 1/2
//     -> grants alternate 0,1,0,1; RegWrite=1 continuously; final regs 1 and 2 hold
//        the last data of each requester
//  3. Requester 1 writes reg 31, data 64'hFF
//     -> ready[1]=1; next cycle RegWrite=0; register 31 still reads 0
//  4. hold=1 for 3 cycles with both valid
//     -> req_ready=0, RegWrite=0, pointer unchanged; first grant after release goes to
//        the pre-hold pointer
//  5. Both write reg 5 (r0: 64'h11, r1: 64'h22) in the same cycle, pointer=0
//     -> two consecutive writes; reg 5 ends at 64'h22; fwd_data shows 11 then 22
//  6. Assert reset while RegWrite=1 for reg 7
//     -> RegWrite drops to 0 asynchronously; reg 7 keeps its prior value; pointer=0 after release

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file geometry and writeback request type shared by writeback, forwarding and hazard logic
package regfile_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int ZERO_REG = 31;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant over N requesters; the pointer moves past each winner
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr, nxt, i;
  // Scan from the farthest offset back to the pointer so the nearest valid requester wins.
  always_comb begin
    grant = '0;
    nxt = ptr;
    i = '0;
    for (int k = N - 1; k >= 0; k--) begin
      i = PW'((int'(ptr) + k) % N);
      if (advance && req[i]) begin
        grant = '0;
        grant[i] = 1'b1;
        nxt = (i == PW'(N - 1)) ? '0 : i + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else ptr <= nxt;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port with a registered,
// forwardable output stage that silently drops writes to the zero register
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_reg,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          RegWrite,
  output logic [ADDR_WIDTH-1:0]         WriteRegister,
  output logic [DATA_WIDTH-1:0]         WriteData,
  output logic                          fwd_valid,
  output logic [ADDR_WIDTH-1:0]         fwd_reg,
  output logic [DATA_WIDTH-1:0]         fwd_data
);
  logic [ADDR_WIDTH-1:0] win_reg;
  logic [DATA_WIDTH-1:0] win_data;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk(clk),
    .rst(reset),
    .advance(!hold && !reset),
    .req(req_valid),
    .grant(req_ready)
  );
  always_comb begin
    win_reg = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) begin
        win_reg = req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      RegWrite <= 1'b0;
      WriteRegister <= '0;
      WriteData <= '0;
    end else if (|req_ready) begin
      RegWrite <= win_reg != ADDR_WIDTH'(ZERO_REG);
      WriteRegister <= win_reg;
      WriteData <= win_data;
    end else begin
      RegWrite <= 1'b0;
    end
  assign fwd_valid = RegWrite;
  assign fwd_reg = WriteRegister;
  assign fwd_data = WriteData;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors against a register-file model fed by the write port
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hold = 1'b0;
  logic [1:0] req_valid = '0;
  logic [4:0] r0 = '0, r1 = '0;
  logic [63:0] d0 = '0, d1 = '0;
  logic [1:0] req_ready;
  logic RegWrite, fwd_valid;
  logic [4:0] WriteRegister, fwd_reg;
  logic [63:0] WriteData, fwd_data;
  logic [63:0] rf [32];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  regfile_write_arbiter dut (
    .clk(clk),
    .reset(reset),
    .hold(hold),
    .req_valid(req_valid),
    .req_reg({r1, r0}),
    .req_data({d1, d0}),
    .req_ready(req_ready),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .fwd_valid(fwd_valid),
    .fwd_reg(fwd_reg),
    .fwd_data(fwd_data)
  );
  // Plain register file: commits whatever the write port presents, one edge after the stage.
  always @(posedge clk)
    if (RegWrite) rf[WriteRegister] <= WriteData;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_regwrite", 64'(RegWrite), 64'h0);
    chk("rst_wreg", 64'(WriteRegister), 64'h0);
    chk("rst_wdata", WriteData, 64'h0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'h0);
    tick();
    req_valid = 2'b00;
    reset = 1'b0;
    // 1: single write to reg 3
    req_valid = 2'b01; r0 = 5'd3; d0 = 64'hA5;
    #1 chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    chk("t1_regwrite", 64'(RegWrite), 64'h1);
    chk("t1_wreg", 64'(WriteRegister), 64'h3);
    chk("t1_wdata", WriteData, 64'hA5);
    chk("t1_fwd_valid", 64'(fwd_valid), 64'h1);
    chk("t1_fwd_reg", 64'(fwd_reg), 64'h3);
    chk("t1_fwd_data", fwd_data, 64'hA5);
    tick();
    chk("t1_idle_regwrite", 64'(RegWrite), 64'h0);
    chk("t1_idle_hold_reg", 64'(WriteRegister), 64'h3);
    chk("t1_commit", rf[3], 64'hA5);
    // 2: both valid on regs 1/2; pointer sits at 1 after test 1
    r0 = 5'd1; r1 = 5'd2;
    for (int c = 0; c < 4; c++) begin
      req_valid = 2'b11; d0 = 64'h100 + 64'(c); d1 = 64'h200 + 64'(c);
      #1 chk("t2_ready", 64'(req_ready), (c % 2 == 0) ? 64'h2 : 64'h1);
      tick();
      chk("t2_regwrite", 64'(RegWrite), 64'h1);
      chk("t2_wreg", 64'(WriteRegister), (c % 2 == 0) ? 64'h2 : 64'h1);
    end
    req_valid = 2'b00;
    tick();
    tick();
    chk("t2_reg1", rf[1], 64'h103);
    chk("t2_reg2", rf[2], 64'h202);
    // 3: write to the zero register is dropped; pointer at 1
    req_valid = 2'b10; r1 = 5'd31; d1 = 64'hFF;
    #1 chk("t3_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    chk("t3_regwrite", 64'(RegWrite), 64'h0);
    tick();
    chk("t3_reg31", rf[31], 64'h0);
    // 4: hold blocks grants and freezes the pointer (at 0)
    hold = 1'b1; req_valid = 2'b11; r0 = 5'd8; r1 = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t4_hold_ready", 64'(req_ready), 64'h0);
      tick();
      chk("t4_hold_regwrite", 64'(RegWrite), 64'h0);
    end
    hold = 1'b0;
    #1 chk("t4_release_ready", 64'(req_ready), 64'h1);
    req_valid = 2'b00;
    tick();
    chk("t4_drop_regwrite", 64'(RegWrite), 64'h0);
    // 5: both target reg 5, pointer 0
    req_valid = 2'b11; r0 = 5'd5; r1 = 5'd5; d0 = 64'h11; d1 = 64'h22;
    #1 chk("t5_ready0", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    chk("t5_fwd0", fwd_data, 64'h11);
    chk("t5_fwd_reg0", 64'(fwd_reg), 64'h5);
    #1 chk("t5_ready1", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    chk("t5_fwd1", fwd_data, 64'h22);
    chk("t5_fwd_valid1", 64'(fwd_valid), 64'h1);
    tick();
    chk("t5_reg5", rf[5], 64'h22);
    // 6: reset discards an in-flight write
    req_valid = 2'b01; r0 = 5'd7; d0 = 64'h77;
    tick();
    req_valid = 2'b00;
    tick();
    chk("t6_prior", rf[7], 64'h77);
    req_valid = 2'b01; d0 = 64'h99;
    tick();
    req_valid = 2'b00;
    chk("t6_inflight", 64'(RegWrite), 64'h1);
    #2 reset = 1'b1;
    #1 chk("t6_async_regwrite", 64'(RegWrite), 64'h0);
    chk("t6_async_fwd_valid", 64'(fwd_valid), 64'h0);
    chk("t6_async_wreg", 64'(WriteRegister), 64'h0);
    tick();
    reset = 1'b0;
    req_valid = 2'b11;
    #1 chk("t6_ptr_reset", 64'(req_ready), 64'h1);
    chk("t6_reg7_kept", rf[7], 64'h77);
    req_valid = 2'b00;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
